// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo alert scheduler.
// Tune encoding doubles as priority: a lower code outranks a higher one.
package piezo_pkg;

  typedef enum logic [1:0] {
    TUNE_NONE  = 2'd0,
    TUNE_FAST  = 2'd1,
    TUNE_BATT  = 2'd2,
    TUNE_STEER = 2'd3
  } tune_t;

  localparam int CLK_HZ          = 50_000_000;
  localparam int REPEAT_CLKS_DEF = 150_000_000;

  // Hold-off decrement per clock; the large step shortens simulated hold-offs.
  function automatic logic [27:0] step(input logic fast_sim);
    if (fast_sim) begin
      return 28'd64;
    end else begin
      return 28'd1;
    end
  endfunction

endpackage

// File: rtl/holdoff_tmr.sv
// Per-source repeat hold-off: load on completion, clear while the request is
// low, otherwise count down to zero and stay there.
module holdoff_tmr
  import piezo_pkg::*;
#(
  parameter logic fast_sim    = 1'b1,
  parameter int   REPEAT_CLKS = REPEAT_CLKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  output logic zero
);

  localparam logic [27:0] INCR     = step(fast_sim);
  localparam logic [27:0] LOAD_VAL = 28'(REPEAT_CLKS);

  logic [27:0] cnt;

  // Clear beats load so a completion with the request already gone leaves no hold-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 28'd0;
    end else if (clr) begin
      cnt <= 28'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt <= INCR) begin
      cnt <= 28'd0;
    end else begin
      cnt <= cnt - INCR;
    end
  end

  assign zero = (cnt == 28'd0);

endmodule

// File: rtl/piezo_sched.sv
// Fixed-priority scheduler sharing one piezo tune player between the
// too_fast, batt_low and en_steer alerts, with pre-emption and repeat hold-off.
module piezo_sched
  import piezo_pkg::*;
#(
  parameter logic fast_sim    = 1'b1,
  parameter int   REPEAT_CLKS = 150_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       too_fast,
  input  logic       batt_low,
  input  logic       en_steer,
  input  logic       player_busy,
  input  logic       player_done,
  output logic       start,
  output logic       abort,
  output logic [1:0] tune,
  output logic [1:0] active
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        start_nxt, abort_nxt;
  logic [1:0]  tune_nxt, active_nxt;
  logic        load_batt, load_steer;
  logic        batt_clear, steer_clear;
  logic        elig_fast, elig_batt, elig_steer;
  logic [1:0]  win;

  holdoff_tmr #(.fast_sim(fast_sim), .REPEAT_CLKS(REPEAT_CLKS)) u_hold_batt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_batt),
    .clr   (!batt_low),
    .zero  (batt_clear)
  );

  holdoff_tmr #(.fast_sim(fast_sim), .REPEAT_CLKS(REPEAT_CLKS)) u_hold_steer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_steer),
    .clr   (!en_steer),
    .zero  (steer_clear)
  );

  assign elig_fast  = too_fast;
  assign elig_batt  = batt_low && batt_clear;
  assign elig_steer = en_steer && steer_clear;

  // Highest-priority eligible source, TUNE_NONE when nothing is eligible.
  always_comb begin
    win = TUNE_NONE;
    if (elig_fast) begin
      win = TUNE_FAST;
    end else if (elig_batt) begin
      win = TUNE_BATT;
    end else if (elig_steer) begin
      win = TUNE_STEER;
    end else begin
      win = TUNE_NONE;
    end
  end

  // Next-state and next-output logic; player_done is tested before pre-emption.
  always_comb begin
    state_nxt  = state;
    start_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    tune_nxt   = TUNE_NONE;
    active_nxt = active;
    load_batt  = 1'b0;
    load_steer = 1'b0;
    case (state)
      S_IDLE: begin
        if (win != TUNE_NONE) begin
          start_nxt  = 1'b1;
          tune_nxt   = win;
          active_nxt = win;
          state_nxt  = S_PLAY;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      S_PLAY: begin
        if (player_done) begin
          load_batt  = (active == TUNE_BATT);
          load_steer = (active == TUNE_STEER);
          active_nxt = TUNE_NONE;
          state_nxt  = S_IDLE;
        end else if ((win != TUNE_NONE) && (win < active)) begin
          abort_nxt  = 1'b1;
          state_nxt  = S_DRAIN;
        end else begin
          state_nxt  = S_PLAY;
        end
      end
      S_DRAIN: begin
        if (!player_busy) begin
          active_nxt = TUNE_NONE;
          state_nxt  = S_IDLE;
        end else begin
          state_nxt  = S_DRAIN;
        end
      end
      default: begin
        active_nxt = TUNE_NONE;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      start  <= 1'b0;
      abort  <= 1'b0;
      tune   <= 2'd0;
      active <= 2'd0;
    end else begin
      state  <= state_nxt;
      start  <= start_nxt;
      abort  <= abort_nxt;
      tune   <= tune_nxt;
      active <= active_nxt;
    end
  end

endmodule

// File: tb/tb_piezo_sched.sv
// Bench for piezo_sched: cycle table, directed corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_piezo_sched;

  localparam int REP  = 6400;
  localparam int HOLD = REP / 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       too_fast = 1'b0, batt_low = 1'b0, en_steer = 1'b0;
  logic       player_busy = 1'b0, player_done = 1'b0;
  logic       start, abort;
  logic [1:0] tune, active;

  int n_tests = 0;
  int n_fail  = 0;

  piezo_sched #(.fast_sim(1'b1), .REPEAT_CLKS(REP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .too_fast    (too_fast),
    .batt_low    (batt_low),
    .en_steer    (en_steer),
    .player_busy (player_busy),
    .player_done (player_done),
    .start       (start),
    .abort       (abort),
    .tune        (tune),
    .active      (active)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [4:0] in;   // {too_fast, batt_low, en_steer, player_busy, player_done}
    logic       st;
    logic       ab;
    logic [1:0] tu;
    logic [1:0] ac;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int s, input int a, input int t, input int ac);
    check({tag, " start"}, int'(start), s);
    check({tag, " abort"}, int'(abort), a);
    check({tag, " tune"}, int'(tune), t);
    check({tag, " active"}, int'(active), ac);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {too_fast, batt_low, en_steer, player_busy, player_done} = 5'b00000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle_in(input logic [4:0] in);
    @(negedge clk);
    {too_fast, batt_low, en_steer, player_busy, player_done} = in;
    @(posedge clk);
    #1;
  endtask

  // Reference model: hold-offs kept as "eligible from edge N" timestamps.
  int     mode;      // 0 waiting, 1 sounding, 2 waiting for abort to take effect
  int     owner;
  longint free_b, free_s, edge_no;

  task automatic model_step(output int es, output int ea, output int et);
    int cand;
    es = 0; ea = 0; et = 0;
    edge_no++;
    cand = 0;
    if (too_fast) cand = 1;
    else if (batt_low && edge_no >= free_b) cand = 2;
    else if (en_steer && edge_no >= free_s) cand = 3;
    if (mode == 0) begin
      if (cand != 0) begin
        es = 1; et = cand; owner = cand; mode = 1;
      end
    end else if (mode == 1) begin
      if (player_done) begin
        if (owner == 2) free_b = edge_no + HOLD + 1;
        if (owner == 3) free_s = edge_no + HOLD + 1;
        owner = 0; mode = 0;
      end else if (cand != 0 && cand < owner) begin
        ea = 1; mode = 2;
      end
    end else begin
      if (!player_busy) begin
        owner = 0; mode = 0;
      end
    end
    if (!batt_low) free_b = 0;
    if (!en_steer) free_s = 0;
  endtask

  initial begin
    int n, got_start, rem, drain_left, aborting;
    int es, ea, et;

    tbl[0]  = '{5'b00000, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{5'b01000, 1'b1, 1'b0, 2'd2, 2'd2};
    tbl[2]  = '{5'b01010, 1'b0, 1'b0, 2'd0, 2'd2};
    tbl[3]  = '{5'b11010, 1'b0, 1'b1, 2'd0, 2'd2};
    tbl[4]  = '{5'b11010, 1'b0, 1'b0, 2'd0, 2'd2};
    tbl[5]  = '{5'b11000, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[6]  = '{5'b11000, 1'b1, 1'b0, 2'd1, 2'd1};
    tbl[7]  = '{5'b11010, 1'b0, 1'b0, 2'd0, 2'd1};
    tbl[8]  = '{5'b11011, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[9]  = '{5'b11000, 1'b1, 1'b0, 2'd1, 2'd1};
    tbl[10] = '{5'b01010, 1'b0, 1'b0, 2'd0, 2'd1};
    tbl[11] = '{5'b01011, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[12] = '{5'b01000, 1'b1, 1'b0, 2'd2, 2'd2};
    tbl[13] = '{5'b01011, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[14] = '{5'b01000, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[15] = '{5'b01100, 1'b1, 1'b0, 2'd3, 2'd3};
    tbl[16] = '{5'b01110, 1'b0, 1'b0, 2'd0, 2'd3};
    tbl[17] = '{5'b10111, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[18] = '{5'b10100, 1'b1, 1'b0, 2'd1, 2'd1};
    tbl[19] = '{5'b10111, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[20] = '{5'b00100, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[21] = '{5'b00000, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[22] = '{5'b00100, 1'b1, 1'b0, 2'd3, 2'd3};
    tbl[23] = '{5'b00111, 1'b0, 1'b0, 2'd0, 2'd0};

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0);
    do_reset();

    // Cycle table: pre-emption, FAST repeat, hold-off, done-vs-preempt, clear.
    for (int i = 0; i < 24; i++) begin
      cycle_in(tbl[i].in);
      check_outs($sformatf("tbl[%0d]", i), int'(tbl[i].st), int'(tbl[i].ab),
                 int'(tbl[i].tu), int'(tbl[i].ac));
    end

    // Single STEER request: hold-off expiry restarts after HOLD+1 edges.
    do_reset();
    cycle_in(5'b00100);
    check_outs("single start", 1, 0, 3, 3);
    cycle_in(5'b00110);
    check_outs("single play", 0, 0, 0, 3);
    cycle_in(5'b00111);
    check_outs("single done", 0, 0, 0, 0);
    @(negedge clk);
    player_busy = 1'b0;
    player_done = 1'b0;
    n = 0;
    got_start = 0;
    while (n < 300 && got_start == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (start) got_start = 1;
    end
    check("steer holdoff gap", n, HOLD + 1);
    check("steer restart tune", int'(tune), 3);

    // Reset mid-tune: everything to zero, no abort, stays quiet afterwards.
    @(negedge clk);
    player_busy = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    en_steer = 1'b0;
    player_busy = 1'b0;
    #1;
    check_outs("async reset", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs("in reset", 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs("after reset", 0, 0, 0, 0);
    end

    // Simultaneous requests resolve by priority, then lower ones follow.
    do_reset();
    cycle_in(5'b11100);
    check_outs("simul fast", 1, 0, 1, 1);
    cycle_in(5'b01110);
    check_outs("simul fast play", 0, 0, 0, 1);
    cycle_in(5'b01111);
    check_outs("simul fast done", 0, 0, 0, 0);
    cycle_in(5'b01100);
    check_outs("simul batt", 1, 0, 2, 2);
    cycle_in(5'b01111);
    check_outs("simul batt done", 0, 0, 0, 0);
    cycle_in(5'b01100);
    check_outs("simul steer", 1, 0, 3, 3);

    // Randomized run with a reactive player against the reference model.
    do_reset();
    mode = 0; owner = 0; free_b = 0; free_s = 0; edge_no = 0;
    rem = 0; drain_left = 0; aborting = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      player_done = 1'b0;
      if (start) begin
        player_busy = 1'b1;
        rem = int'($urandom_range(1, 14));
      end else if (abort) begin
        aborting = 1;
        drain_left = int'($urandom_range(0, 3));
      end
      if (aborting != 0) begin
        if (drain_left == 0) begin
          player_busy = 1'b0;
          aborting = 0;
        end else begin
          drain_left--;
        end
      end else if (player_busy && !start) begin
        if (rem == 0) begin
          player_done = 1'b1;
          player_busy = 1'b0;
        end else begin
          rem--;
        end
      end
      if ($urandom_range(0, 59) == 0) too_fast = ~too_fast;
      if ($urandom_range(0, 29) == 0) batt_low = ~batt_low;
      if ($urandom_range(0, 29) == 0) en_steer = ~en_steer;
      @(posedge clk);
      model_step(es, ea, et);
      #1;
      check_outs($sformatf("rnd c%0d", c), es, ea, et, owner);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
